op_dispatcher: RTL and testbench

//   Upstream sequencer for the timer and sibling peripherals. It pops 32-bit

---
 rtl/op_dispatcher.sv | 159 +++++++++++++++
 tb/tb_op_dispatcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_dispatcher.sv
// op_dispatcher: pops instruction words from a 1-cycle-latency FIFO and
// issues each one to its target as a single cs pulse with op/data_out. It then
// blocks until that target reports ready again, so targets run strictly in order.
module op_dispatcher #(
  parameter int N_TGT   = 4,
  parameter int TIMEOUT = 2**24,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [N_TGT-1:0] cs,
  output logic [3:0]       op,
  output logic [23:0]      data_out,
  input  logic [N_TGT-1:0] rdy,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] issued
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_GUARD, S_WAIT
  } state_t;

  state_t state, state_nxt;

  // Fields of the word currently presented by the FIFO
  logic [3:0]       word_op;
  logic [3:0]       word_tgt;
  logic [23:0]      word_data;
  logic             word_bad;
  logic [N_TGT-1:0] word_sel;

  // Latched instruction and held outputs
  logic [3:0]       op_lat;
  logic [23:0]      data_lat;
  logic [N_TGT-1:0] sel_q;
  logic [3:0]       op_q;
  logic [23:0]      data_q;
  logic [TMO_W-1:0] tmo_cnt;

  // Decoded FSM actions
  logic             rdy_sel;
  logic             tmo_hit;
  logic             fire;
  logic             abort;
  logic             bad;

  assign word_op   = fifo_dout[31:28];
  assign word_tgt  = fifo_dout[27:24];
  assign word_data = fifo_dout[23:0];
  assign word_bad  = (int'(word_tgt) >= N_TGT);
  assign word_sel  = N_TGT'(1) << word_tgt;

  // Ready of the selected target only; sel_q is one-hot for any issued word
  assign rdy_sel = |(rdy & sel_q);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  // Outputs: cs only in the firing ISSUE cycle, op/data follow the word then hold
  assign cs       = fire ? sel_q : '0;
  assign op       = fire ? op_lat : op_q;
  assign data_out = fire ? data_lat : data_q;
  assign busy     = (state != S_IDLE);

  // Next-state decode and per-state action strobes
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    abort     = 1'b0;
    bad       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !fifo_empty) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (word_bad) begin
          bad       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rdy_sel) begin
          fire      = 1'b1;
          state_nxt = S_GUARD;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GUARD: begin
        // The target only drops rdy the cycle after cs, so rdy is not looked at here
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_sel) begin
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, pop strobe, timeout counter, error flag and issue counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      sel_q      <= '0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      issued     <= '0;
    end else begin
      state      <= state_nxt;
      fifo_rd_en <= (state == S_IDLE) && (state_nxt == S_FETCH);
      if (state == S_LATCH) sel_q <= word_sel;
      if ((state == S_LATCH) || (state == S_GUARD)) begin
        tmo_cnt <= '0;
      end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (bad || abort) err <= 1'b1;
      if (fire) issued <= issued + CNT_W'(1);
    end
  end

  // Held op/data_out, updated only when a word is actually issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      data_q <= '0;
    end else if (fire) begin
      op_q   <= op_lat;
      data_q <= data_lat;
    end
  end

  // Instruction payload captured from the FIFO; never needs a reset value
  always_ff @(posedge clk) begin
    if (state == S_LATCH) begin
      op_lat   <= word_op;
      data_lat <= word_data;
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher: a main instance (TIMEOUT=1000, CNT_W=4)
// driving a timer model on target 0, and a second instance (TIMEOUT=50)
// whose target 1 never becomes ready.
module tb_op_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance signals
  logic        en_a;
  logic [31:0] dout_a;
  logic        empty_a;
  logic        rd_a;
  logic [3:0]  cs_a;
  logic [3:0]  op_a;
  logic [23:0] dat_a;
  logic [3:0]  rdy_a;
  logic        busy_a;
  logic        err_a;
  logic [3:0]  iss_a;

  // Timeout instance signals
  logic        en_b;
  logic [31:0] dout_b;
  logic        empty_b;
  logic        rd_b;
  logic [3:0]  cs_b;
  logic [3:0]  op_b;
  logic [23:0] dat_b;
  logic [3:0]  rdy_b;
  logic        busy_b;
  logic        err_b;
  logic [15:0] iss_b;

  op_dispatcher #(.N_TGT(4), .TIMEOUT(1000), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en_a), .fifo_dout(dout_a), .fifo_empty(empty_a),
    .fifo_rd_en(rd_a), .cs(cs_a), .op(op_a), .data_out(dat_a), .rdy(rdy_a),
    .busy(busy_a), .err(err_a), .issued(iss_a)
  );

  op_dispatcher #(.N_TGT(4), .TIMEOUT(50), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .en(en_b), .fifo_dout(dout_b), .fifo_empty(empty_b),
    .fifo_rd_en(rd_b), .cs(cs_b), .op(op_b), .data_out(dat_b), .rdy(rdy_b),
    .busy(busy_b), .err(err_b), .issued(iss_b)
  );

  // FIFO models with one cycle of read latency
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:7];
  int wr_a = 0, rp_a = 0, wr_b = 0, rp_b = 0;
  assign empty_a = (wr_a == rp_a);
  assign empty_b = (wr_b == rp_b);

  always @(posedge clk) begin
    if (rd_a) begin
      dout_a <= mem_a[rp_a[5:0]];
      rp_a   <= rp_a + 1;
    end
    if (rd_b) begin
      dout_b <= mem_b[rp_b[2:0]];
      rp_b   <= rp_b + 1;
    end
  end

  // Timer model on target 0: counts data_out+1 cycles after cs, rdy = ~counting
  logic        tmr_cnting = 1'b0;
  logic [23:0] tmr_cnt = '0;
  always @(posedge clk) begin
    if (cs_a[0]) begin
      tmr_cnting <= 1'b1;
      tmr_cnt    <= dat_a;
    end else if (tmr_cnting) begin
      if (tmr_cnt == 24'd0) tmr_cnting <= 1'b0;
      else tmr_cnt <= tmr_cnt - 24'd1;
    end
  end
  assign rdy_a = {3'b111, ~tmr_cnting};
  assign rdy_b = 4'b1101;

  // Pulse log, sampled on the falling edge
  int          cyc = 0, cs_n = 0, ovl = 0, multi = 0, rd_n_a = 0, b_cs_n = 0;
  logic [23:0] cs_dat [0:63];
  logic [3:0]  cs_sel [0:63];
  int          cs_t   [0:63];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_a) rd_n_a <= rd_n_a + 1;
    if (cs_b != 4'd0) b_cs_n <= b_cs_n + 1;
    if (cs_a != 4'd0) begin
      cs_dat[cs_n[5:0]] <= dat_a;
      cs_sel[cs_n[5:0]] <= cs_a;
      cs_t[cs_n[5:0]]   <= cyc;
      cs_n              <= cs_n + 1;
      if (cs_a[0] && tmr_cnting) ovl <= ovl + 1;
      if (!$onehot(cs_a)) multi <= multi + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] w);
    mem_a[wr_a[5:0]] = w;
    wr_a++;
  endtask

  task automatic push_b(input logic [31:0] w);
    mem_b[wr_b[2:0]] = w;
    wr_b++;
  endtask

  task automatic wait_cs_a(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (cs_a != 4'd0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_quiet_a(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (!busy_a && empty_a) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_a), 32'h0);
    chk({tag, "_cs"},    32'(cs_a), 32'h0);
    chk({tag, "_op"},    32'(op_a), 32'h0);
    chk({tag, "_data"},  32'(dat_a), 32'h0);
    chk({tag, "_busy"},  32'(busy_a), 32'h0);
    chk({tag, "_err"},   32'(err_a), 32'h0);
    chk({tag, "_iss"},   32'(iss_a), 32'h0);
  endtask

  initial begin
    int n, base, rdn0;
    rst  = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1: single timer word, data 100
    push_a(32'h0000_0064);
    wait_cs_a(20, n);
    chk("t1_issue_lat", n, 3);
    chk("t1_cs", 32'(cs_a), 32'h1);
    chk("t1_data", 32'(dat_a), 32'h64);
    chk("t1_op", 32'(op_a), 32'h0);
    wait_quiet_a(300, n);
    chk("t1_busy_cycles", n, 103);
    chk("t1_iss", 32'(iss_a), 32'h1);
    chk("t1_hold_data", 32'(dat_a), 32'h64);

    // 2: three back-to-back timer words
    base = cs_n;
    push_a(32'h0000_000A);
    push_a(32'h0000_0014);
    push_a(32'h0000_001E);
    wait_quiet_a(400, n);
    chk("t2_pulses", cs_n - base, 3);
    chk("t2_d0", 32'(cs_dat[base]), 32'h0A);
    chk("t2_d2", 32'(cs_dat[base + 2]), 32'h1E);
    chk("t2_gap01", cs_t[base + 1] - cs_t[base], 16);
    chk("t2_gap12", cs_t[base + 2] - cs_t[base + 1], 26);
    chk("t2_overlap", ovl, 0);
    chk("t2_iss", 32'(iss_a), 32'h4);

    // 3: bad target, then a valid word
    chk("t3_err_pre", 32'(err_a), 32'h0);
    base = cs_n;
    push_a(32'h0700_0005);
    push_a(32'h0000_0003);
    wait_quiet_a(100, n);
    chk("t3_err", 32'(err_a), 32'h1);
    chk("t3_pulses", cs_n - base, 1);
    chk("t3_sel", 32'(cs_sel[base]), 32'h1);
    chk("t3_data", 32'(cs_dat[base]), 32'h3);
    chk("t3_iss", 32'(iss_a), 32'h5);

    // 5: reset during WAIT, restart takes the following word
    push_a(32'h0000_0032);
    push_a(32'h0000_0008);
    wait_cs_a(20, n);
    chk("t5_first_data", 32'(dat_a), 32'h32);
    repeat (4) @(negedge clk);
    chk("t5_busy_wait", 32'(busy_a), 32'h1);
    rst = 1'b1;
    #1;
    chk_reset("t5_async");
    @(negedge clk);
    rst = 1'b0;
    wait_cs_a(200, n);
    chk("t5_restart_cs", 32'(cs_a), 32'h1);
    chk("t5_restart_data", 32'(dat_a), 32'h8);
    wait_quiet_a(100, n);
    chk("t5_iss", 32'(iss_a), 32'h1);
    chk("t5_err", 32'(err_a), 32'h0);

    // 6: en gating, then issue-counter wrap
    en_a = 1'b0;
    rdn0 = rd_n_a;
    push_a(32'h0300_0002);
    repeat (6) @(negedge clk);
    chk("t6_no_pop", rd_n_a - rdn0, 0);
    chk("t6_idle", 32'(busy_a), 32'h0);
    en_a = 1'b1;
    @(negedge clk);
    chk("t6_pop", 32'(rd_a), 32'h1);
    wait_quiet_a(50, n);
    chk("t6_iss", 32'(iss_a), 32'h2);
    for (int i = 0; i < 13; i++) push_a(32'h0300_0000 | 32'(i));
    wait_quiet_a(300, n);
    chk("t6_iss_max", 32'(iss_a), 32'hF);
    push_a(32'h0300_0055);
    wait_quiet_a(50, n);
    chk("t6_wrap", 32'(iss_a), 32'h0);

    // 4: target 1 never ready on the TIMEOUT=50 instance
    push_b(32'h0100_0005);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (err_b) begin
        n = i;
        break;
      end
    end
    chk("t4_tmo_cycles", n, 53);
    chk("t4_idle", 32'(busy_b), 32'h0);
    chk("t4_no_cs", b_cs_n, 0);
    chk("t4_iss", 32'(iss_b), 32'h0);
    push_b(32'h0200_0007);
    @(negedge clk);
    chk("t4_repop", 32'(rd_b), 32'h1);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cs_b != 4'd0) begin
        n = i;
        break;
      end
    end
    chk("t4_cs_lat", n, 2);
    chk("t4_cs", 32'(cs_b), 32'h4);
    chk("t4_data", 32'(dat_b), 32'h7);
    repeat (4) @(negedge clk);
    chk("t4_iss_after", 32'(iss_b), 32'h1);
    chk("t4_err_sticky", 32'(err_b), 32'h1);

    chk("cs_onehot", multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
